// File: rtl/d_imm_ext_pipe.sv
// Immediate extender for the D->E boundary: zero/sign/upper/branch extension followed by a
// STAGES-deep register pipeline with valid bit, stall hold and flush-to-bubble.
module d_imm_ext_pipe #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       ext_op,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out,
    output logic [1:0]       out_op
);

    if ((IN_W < 1) || (IN_W + 2 > OUT_W)) begin : g_bad_in_w
        $error("d_imm_ext_pipe: IN_W=%0d illegal for OUT_W=%0d", IN_W, OUT_W);
    end
    if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
        $error("d_imm_ext_pipe: STAGES=%0d outside 1..4", STAGES);
    end

    localparam int unsigned PadW = OUT_W - IN_W;

    logic [OUT_W-1:0] zext, sext, upper, branch, ext_val;

    always_comb begin
        zext   = {{PadW{1'b0}}, in};
        sext   = {{PadW{in[IN_W-1]}}, in};
        upper  = {in, {PadW{1'b0}}};
        // Bits pushed past the MSB by the word-offset shift are discarded.
        branch = {sext[OUT_W-3:0], 2'b00};
        ext_val = zext;
        unique case (ext_op)
            2'b00:   ext_val = zext;
            2'b01:   ext_val = sext;
            2'b10:   ext_val = upper;
            default: ext_val = branch;
        endcase
    end

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][OUT_W-1:0] data_q, data_d;
    logic [STAGES-1:0][1:0]       op_q, op_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        if (flush) begin
            valid_d = '0;
            data_d  = '0;
            op_d    = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            data_d[0]  = ext_val;
            op_d[0]    = ext_op;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                op_d[k]    = op_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out       = data_q[STAGES-1];
    assign out_op    = op_q[STAGES-1];

endmodule

// File: tb/tb_d_imm_ext_pipe.sv
// Scoreboard bench: four 16->32 pipes (STAGES 1..4) on shared stimulus plus an 8->16 pipe.
module tb_d_imm_ext_pipe;

    localparam int NDut = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, stall, flush;
    logic [15:0] in_w;
    logic [1:0]  ext_op;

    logic        out_valid_s [NDut];
    logic [31:0] out_s [NDut];
    logic [1:0]  op_s [NDut];

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        d_imm_ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(g + 1)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .in       (in_w),
            .ext_op   (ext_op),
            .stall    (stall),
            .flush    (flush),
            .out_valid(out_valid_s[g]),
            .out      (out_s[g]),
            .out_op   (op_s[g])
        );
    end

    logic       valid8, outv8;
    logic [7:0] in8;
    logic [1:0] op8, outop8;
    logic [15:0] out8;

    d_imm_ext_pipe #(.IN_W(8), .OUT_W(16), .STAGES(1)) u_dut_n8 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (valid8),
        .in       (in8),
        .ext_op   (op8),
        .stall    (stall),
        .flush    (flush),
        .out_valid(outv8),
        .out      (out8),
        .out_op   (outop8)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  op;
        int unsigned due;
    } sb_t;

    sb_t         sb_q [NDut][$];
    int unsigned adv;
    logic        last_v [NDut];
    logic [31:0] last_d [NDut];
    logic [1:0]  last_op [NDut];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference extension written arithmetically rather than by bit concatenation.
    function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] op);
        logic [31:0] s;
        s = x[15] ? (32'(x) - 32'h0001_0000) : 32'(x);
        case (op)
            2'd0:    return 32'(x);
            2'd1:    return s;
            2'd2:    return 32'(x) * 32'h0001_0000;
            default: return s * 32'd4;
        endcase
    endfunction

    task automatic tick();
        logic r, f, s;
        sb_t  e;
        @(posedge clk);
        r = reset;
        f = flush;
        s = stall;
        if (r || f) begin
            for (int i = 0; i < NDut; i++) sb_q[i].delete();
        end else if (!s) begin
            adv++;
            if (in_valid) begin
                for (int i = 0; i < NDut; i++) begin
                    e.data = ref_ext(in_w, ext_op);
                    e.op   = ext_op;
                    e.due  = adv + i;
                    sb_q[i].push_back(e);
                end
            end
        end
        #1;
        for (int i = 0; i < NDut; i++) begin
            if (r || f) begin
                chk($sformatf("clr_valid[%0d]", i), 32'(out_valid_s[i]), 32'd0);
                chk($sformatf("clr_out[%0d]", i), out_s[i], 32'd0);
                chk($sformatf("clr_op[%0d]", i), 32'(op_s[i]), 32'd0);
            end else if (s) begin
                chk($sformatf("hold_valid[%0d]", i), 32'(out_valid_s[i]), 32'(last_v[i]));
                chk($sformatf("hold_out[%0d]", i), out_s[i], last_d[i]);
                chk($sformatf("hold_op[%0d]", i), 32'(op_s[i]), 32'(last_op[i]));
            end else if (out_valid_s[i]) begin
                chk($sformatf("sb_has_entry[%0d]", i), 32'(sb_q[i].size() != 0), 32'd1);
                if (sb_q[i].size() != 0) begin
                    e = sb_q[i].pop_front();
                    chk($sformatf("data[%0d]", i), out_s[i], e.data);
                    chk($sformatf("op[%0d]", i), 32'(op_s[i]), 32'(e.op));
                    chk($sformatf("latency[%0d]", i), adv, e.due);
                end
            end else if (sb_q[i].size() != 0) begin
                chk($sformatf("not_overdue[%0d]", i), 32'(sb_q[i][0].due > adv), 32'd1);
            end
            last_v[i]  = out_valid_s[i];
            last_d[i]  = out_s[i];
            last_op[i] = op_s[i];
        end
    endtask

    logic [31:0] t1_exp [4];
    logic [15:0] t6_exp [4];

    initial begin
        t1_exp = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004};
        t6_exp = '{16'h00FF, 16'hFFFF, 16'hFF00, 16'hFFFC};
        adv = 0;
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_w = 16'h0; ext_op = 2'd0;
        valid8 = 1'b0; in8 = 8'h0; op8 = 2'd0;
        tick();
        tick();
        chk("rst_n8_valid", 32'(outv8), 32'd0);
        chk("rst_n8_out", 32'(out8), 32'd0);
        reset = 1'b0;

        // T1: all four modes on 16'h8001, one cycle latency on the STAGES=1 pipe.
        in_w = 16'h8001;
        in_valid = 1'b1;
        for (int op = 0; op < 4; op++) begin
            ext_op = 2'(op);
            tick();
            chk($sformatf("t1_out_op%0d", op), out_s[0], t1_exp[op]);
            chk($sformatf("t1_valid_op%0d", op), 32'(out_valid_s[0]), 32'd1);
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // T2: three back-to-back sign-extended 5s.
        in_w = 16'h0005;
        ext_op = 2'd1;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // T3: stall for 4 cycles in the middle of a stream.
        ext_op = 2'd3;
        for (int k = 0; k < 14; k++) begin
            in_w = 16'(16'h7FF0 + k);
            in_valid = 1'b1;
            stall = (k >= 5 && k < 9);
            tick();
        end
        stall = 1'b0;
        in_valid = 1'b0;
        repeat (5) tick();

        // T4: stall and flush together with a full pipe, then one fresh capture.
        ext_op = 2'd2;
        for (int k = 0; k < 4; k++) begin
            in_w = 16'(16'hA000 + k);
            in_valid = 1'b1;
            tick();
        end
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        in_w = 16'h1234;
        ext_op = 2'd1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // T5: reset mid-stream; nothing stale may emerge afterwards.
        ext_op = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_w = 16'(16'h00C0 + k);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (6) tick();

        // T6: narrow 8->16 instance.
        in8 = 8'hFF;
        valid8 = 1'b1;
        for (int op = 0; op < 4; op++) begin
            op8 = 2'(op);
            tick();
            chk($sformatf("t6_out_op%0d", op), 32'(out8), 32'(t6_exp[op]));
            chk($sformatf("t6_valid_op%0d", op), 32'(outv8), 32'd1);
            chk($sformatf("t6_opout_op%0d", op), 32'(outop8), 32'(op));
        end
        valid8 = 1'b0;
        tick();
        chk("t6_bubble", 32'(outv8), 32'd0);

        // Random traffic with occasional stall, flush and reset.
        for (int k = 0; k < 400; k++) begin
            in_w     = 16'($urandom);
            ext_op   = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            reset    = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < NDut; i++) begin
            chk($sformatf("drained[%0d]", i), 32'(sb_q[i].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
